// File: rtl/bk_sector_seq_if.sv
// Host sector handshake between the save-state sequencer and the HPS block interface.
interface bk_sector_seq_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/bk_sector_seq.sv
// Save-state sector sequencer: walks every sector of a backup-RAM slot through the
// host sector handshake on a load/save request, with ack timeout and mount tracking.
module bk_sector_seq #(
  parameter int SECT_BITS = 6,
  parameter int SLOT_BITS = 2,
  parameter int TMO_BITS  = 24
) (
  input  logic                 clk_sys,
  input  logic                 RESET_n,
  input  logic                 downloading,
  input  logic                 img_mounted,
  input  logic                 img_readonly,
  input  logic [63:0]          img_size,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  bk_sector_seq_if.master      sd,
  output logic                 bk_ena,
  output logic                 bk_state,
  output logic                 bk_loading,
  output logic                 bk_done,
  output logic                 bk_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [1:0]          state;
  logic                dl_q;
  logic                ld_q, ld_p;
  logic                sv_q, sv_p;
  logic                ack_q;
  logic [TMO_BITS-1:0] tmo;
  logic [TMO_BITS-1:0] tmo_inc;
  logic                tmo_exp;
  logic [31:0]         lba;
  logic [31:0]         start_lba;
  logic                rd, wr;
  logic                ena_set;
  logic                ld_edge, sv_edge;
  logic                ack_rise, ack_fall;
  logic                last_sect;

  assign sd.sd_lba = lba;
  assign sd.sd_rd  = rd;
  assign sd.sd_wr  = wr;

  always_comb begin
    ena_set   = downloading & img_mounted & (img_size != '0) & ~img_readonly;
    ld_edge   = ld_q & ~ld_p;
    sv_edge   = sv_q & ~sv_p;
    ack_rise  = sd.sd_ack & ~ack_q;
    ack_fall  = ~sd.sd_ack & ack_q;
    tmo_inc   = tmo + 1'b1;
    // Expiry fires on the cycle the counter would reach all-ones.
    tmo_exp   = &tmo_inc;
    last_sect = &lba[SECT_BITS-1:0];
    start_lba = 32'({slot, {SECT_BITS{1'b0}}});
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      ld_q       <= 1'b0;
      ld_p       <= 1'b0;
      sv_q       <= 1'b0;
      sv_p       <= 1'b0;
      ack_q      <= 1'b0;
      tmo        <= '0;
      lba        <= '0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      bk_ena     <= 1'b0;
      bk_state   <= 1'b0;
      bk_loading <= 1'b0;
      bk_done    <= 1'b0;
      bk_err     <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (ena_set)
        bk_ena <= 1'b1;
      else if (downloading && !dl_q)
        bk_ena <= 1'b0;

      ld_q    <= load_req & bk_ena;
      ld_p    <= ld_q;
      sv_q    <= save_req & bk_ena;
      sv_p    <= sv_q;
      ack_q   <= sd.sd_ack;
      bk_done <= 1'b0;

      case (state)
        S_IDLE: begin
          tmo <= '0;
          if (ld_edge || sv_edge) begin
            state      <= S_REQ;
            lba        <= start_lba;
            bk_loading <= ld_edge;
            bk_state   <= 1'b1;
            bk_err     <= 1'b0;
            rd         <= ld_edge;
            wr         <= ~ld_edge;
          end
        end

        S_REQ: begin
          if (tmo_exp) begin
            state      <= S_IDLE;
            tmo        <= '0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            bk_state   <= 1'b0;
            bk_loading <= 1'b0;
            bk_err     <= 1'b1;
          end else if (ack_rise) begin
            state <= S_XFER;
            tmo   <= '0;
            rd    <= 1'b0;
            wr    <= 1'b0;
          end else begin
            tmo <= tmo_inc;
          end
        end

        S_XFER: begin
          if (tmo_exp) begin
            state      <= S_IDLE;
            tmo        <= '0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            bk_state   <= 1'b0;
            bk_loading <= 1'b0;
            bk_err     <= 1'b1;
          end else if (ack_fall) begin
            tmo <= '0;
            // Terminal check precedes the increment, so the slot bits never change.
            if (last_sect) begin
              state      <= S_IDLE;
              bk_state   <= 1'b0;
              bk_loading <= 1'b0;
              bk_done    <= 1'b1;
            end else begin
              state <= S_REQ;
              lba   <= lba + 32'd1;
              rd    <= bk_loading;
              wr    <= ~bk_loading;
            end
          end else begin
            tmo <= tmo_inc;
          end
        end

        default: begin
          state <= S_IDLE;
          tmo   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bk_sector_seq.sv
// Bench for bk_sector_seq: randomized host/requests against a transaction-level
// model of expected sector requests, plus directed latency and boundary checks.
module tb_bk_sector_seq;
  localparam int unsigned NSECT = 64;

  logic        clk_sys = 1'b0;
  logic        RESET_n = 1'b0;
  logic        downloading = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = '0;
  logic        load_req = 1'b0;
  logic        save_req = 1'b0;
  logic [1:0]  slot = '0;
  logic        bk_ena, bk_state, bk_loading, bk_done, bk_err;

  bk_sector_seq_if sd ();

  bk_sector_seq #(.SECT_BITS(6), .SLOT_BITS(2), .TMO_BITS(4)) dut (
    .clk_sys     (clk_sys),
    .RESET_n     (RESET_n),
    .downloading (downloading),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .img_size    (img_size),
    .load_req    (load_req),
    .save_req    (save_req),
    .slot        (slot),
    .sd          (sd),
    .bk_ena      (bk_ena),
    .bk_state    (bk_state),
    .bk_loading  (bk_loading),
    .bk_done     (bk_done),
    .bk_err      (bk_err)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: ordered list of sector requests the sequencer must issue.
  typedef struct packed {
    logic [31:0] lba;
    logic        rd;
  } req_t;

  req_t        exp_q[$];
  int          done_cnt = 0;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  logic [31:0] last_lba = '0;

  task automatic expect_xfer(input bit load, input int unsigned s, input int unsigned n);
    req_t r;
    for (int unsigned i = 0; i < n; i++) begin
      r.lba = 32'(s * NSECT + i);
      r.rd  = load;
      exp_q.push_back(r);
    end
  endtask

  // Host model: answers each request after a delay, holding ack for a while.
  bit          host_en = 1'b0;
  bit          host_rand = 1'b0;
  int unsigned host_hold = 3;

  initial begin
    sd.sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (host_en && RESET_n && (sd.sd_rd || sd.sd_wr) && !sd.sd_ack) begin
        int unsigned d, h;
        d = host_rand ? $urandom_range(0, 3) : 0;
        h = host_rand ? $urandom_range(1, 5) : host_hold;
        repeat (d) @(negedge clk_sys);
        sd.sd_ack = 1'b1;
        repeat (h) @(negedge clk_sys);
        sd.sd_ack = 1'b0;
      end
    end
  end

  // Compare process: every cycle, DUT requests are matched against the model.
  logic prev_req = 1'b0, prev_state = 1'b0, prev_done = 1'b0;
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!RESET_n) begin
        prev_req   = 1'b0;
        prev_state = 1'b0;
        prev_done  = 1'b0;
      end else begin
        logic cur_req;
        req_t r;
        cur_req = sd.sd_rd | sd.sd_wr;
        if (sd.sd_rd) rd_cyc++;
        if (sd.sd_wr) wr_cyc++;
        if (cur_req) begin
          check("rd_wr_exclusive", sd.sd_rd & sd.sd_wr, 0);
          check("state_during_req", bk_state, 1);
          check("loading_matches_rd", bk_loading, sd.sd_rd);
        end
        if (cur_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got lba %0d rd %0d, expected no request", sd.sd_lba, sd.sd_rd);
          end else begin
            r = exp_q.pop_front();
            check("req_lba", sd.sd_lba, r.lba);
            check("req_is_read", sd.sd_rd, r.rd);
            last_lba = sd.sd_lba;
          end
        end
        if (bk_done) begin
          done_cnt++;
          check("done_single_cycle", prev_done, 0);
          check("done_with_state_fall", {prev_state, bk_state}, 2'b10);
          check("done_after_last_sector", last_lba[5:0], 6'h3F);
        end
        prev_req   = cur_req;
        prev_state = bk_state;
        prev_done  = bk_done;
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic mount(input bit ro);
    downloading = 1'b1;
    tick(2);
    img_size     = 64'd32768;
    img_readonly = ro;
    img_mounted  = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    tick(1);
    downloading = 1'b0;
    tick(2);
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (bk_state && n < budget) begin
      tick(1);
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, w0, n;
    // Reset values
    tick(2);
    check("rst_lba", sd.sd_lba, 0);
    check("rst_rd", sd.sd_rd, 0);
    check("rst_wr", sd.sd_wr, 0);
    check("rst_ena", bk_ena, 0);
    check("rst_state", bk_state, 0);
    check("rst_loading", bk_loading, 0);
    check("rst_done", bk_done, 0);
    check("rst_err", bk_err, 0);
    RESET_n = 1'b1;
    tick(2);

    // Read-only image leaves the sequencer disabled
    mount(1'b1);
    check("ena_readonly", bk_ena, 0);
    load_req = 1'b1;
    tick(6);
    check("readonly_no_start", bk_state, 0);
    load_req = 1'b0;
    tick(2);
    mount(1'b0);
    check("ena_writable", bk_ena, 1);

    // Full load of slot 2, first sector handshaken by hand for latency checks
    slot = 2'd2;
    expect_xfer(1'b1, 2, NSECT);
    d0 = done_cnt; w0 = wr_cyc;
    load_req = 1'b1;
    tick(1);
    check("start_lat_n", sd.sd_rd, 0);
    tick(1);
    check("start_lat_rd", sd.sd_rd, 1);
    check("start_lat_state", bk_state, 1);
    check("start_lat_loading", bk_loading, 1);
    check("start_lba", sd.sd_lba, 128);
    sd.sd_ack = 1'b1;
    tick(1);
    check("ack_drop_rd", sd.sd_rd, 0);
    tick(2);
    sd.sd_ack = 1'b0;
    tick(1);
    check("next_rd", sd.sd_rd, 1);
    check("next_lba", sd.sd_lba, 129);
    host_en = 1'b1;
    wait_done("load_budget", 2000);
    check("load_done_cnt", done_cnt - d0, 1);
    check("load_queue_empty", exp_q.size(), 0);
    check("load_last_lba", last_lba, 191);
    check("load_no_wr", wr_cyc - w0, 0);
    check("load_end_loading", bk_loading, 0);
    load_req = 1'b0;
    tick(3);

    // Simultaneous edges start a load; a save edge mid-load is discarded
    slot = 2'd0;
    expect_xfer(1'b1, 0, NSECT);
    d0 = done_cnt;
    load_req = 1'b1;
    save_req = 1'b1;
    tick(4);
    check("simul_is_load", bk_loading, 1);
    save_req = 1'b0;
    tick(3);
    save_req = 1'b1;
    wait_done("simul_budget", 2000);
    tick(20);
    check("simul_no_save_start", bk_state, 0);
    check("simul_done_cnt", done_cnt - d0, 1);
    check("simul_queue_empty", exp_q.size(), 0);
    load_req = 1'b0;
    save_req = 1'b0;
    tick(3);

    // Save from the top slot stops at the last LBA of the slot
    slot = 2'd3;
    expect_xfer(1'b0, 3, NSECT);
    d0 = done_cnt; r0 = rd_cyc;
    save_req = 1'b1;
    tick(3);
    wait_done("wrap_budget", 2000);
    tick(5);
    check("wrap_last_lba", last_lba, 255);
    check("wrap_no_rd", rd_cyc - r0, 0);
    check("wrap_done_cnt", done_cnt - d0, 1);
    save_req = 1'b0;
    tick(3);

    // Timeout with no host response
    host_en = 1'b0;
    slot = 2'd1;
    expect_xfer(1'b1, 1, 1);
    d0 = done_cnt;
    load_req = 1'b1;
    n = 0;
    while (!sd.sd_rd && n < 10) begin
      tick(1);
      n++;
    end
    check("tmo_start_seen", sd.sd_rd, 1);
    n = 1;
    while (sd.sd_rd && n < 40) begin
      tick(1);
      if (sd.sd_rd) n++;
    end
    check("tmo_rd_cycles", n, 15);
    check("tmo_err", bk_err, 1);
    check("tmo_state", bk_state, 0);
    check("tmo_no_done", done_cnt - d0, 0);
    load_req = 1'b0;
    tick(3);
    check("tmo_err_sticky", bk_err, 1);
    host_en = 1'b1;
    slot = 2'd0;
    expect_xfer(1'b0, 0, NSECT);
    save_req = 1'b1;
    tick(3);
    check("err_cleared", bk_err, 0);
    wait_done("post_tmo_budget", 2000);
    save_req = 1'b0;
    tick(3);

    // ROM download mid-save: enable drops, transfer still completes
    slot = 2'd1;
    expect_xfer(1'b0, 1, NSECT);
    d0 = done_cnt;
    save_req = 1'b1;
    tick(40);
    downloading = 1'b1;
    tick(2);
    check("dl_ena_cleared", bk_ena, 0);
    check("dl_still_busy", bk_state, 1);
    downloading = 1'b0;
    wait_done("dl_budget", 2000);
    check("dl_done_cnt", done_cnt - d0, 1);
    check("dl_queue_empty", exp_q.size(), 0);
    save_req = 1'b0;
    load_req = 1'b1;
    tick(10);
    check("dl_disabled_no_start", bk_state, 0);
    load_req = 1'b0;
    tick(2);

    // Reset after the sector at LBA 70
    mount(1'b0);
    slot = 2'd1;
    expect_xfer(1'b1, 1, 8);
    load_req = 1'b1;
    n = 0;
    while (!(sd.sd_rd && sd.sd_lba == 32'd71) && n < 2000) begin
      tick(1);
      n++;
    end
    check("rst_reach_lba71", sd.sd_lba, 71);
    #1 RESET_n = 1'b0;
    #1;
    check("mid_rst_lba", sd.sd_lba, 0);
    check("mid_rst_rd", sd.sd_rd, 0);
    check("mid_rst_state", bk_state, 0);
    check("mid_rst_loading", bk_loading, 0);
    check("mid_rst_ena", bk_ena, 0);
    tick(2);
    RESET_n = 1'b1;
    tick(20);
    check("post_rst_idle", bk_state, 0);
    check("post_rst_queue_empty", exp_q.size(), 0);
    load_req = 1'b0;
    tick(8);

    // Randomized transfers with discarded requests and slot changes while busy
    mount(1'b0);
    host_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bit          ld;
      int unsigned s;
      ld = 1'($urandom_range(0, 1));
      s  = $urandom_range(0, 3);
      expect_xfer(ld, s, NSECT);
      d0 = done_cnt;
      slot = 2'(s);
      if (ld) load_req = 1'b1;
      else    save_req = 1'b1;
      tick($urandom_range(5, 60));
      slot = 2'($urandom_range(0, 3));
      if (ld) save_req = 1'b1;
      else    load_req = 1'b1;
      wait_done("rand_budget", 3000);
      tick(10);
      check("rand_done_cnt", done_cnt - d0, 1);
      check("rand_queue_empty", exp_q.size(), 0);
      check("rand_idle", bk_state, 0);
      load_req = 1'b0;
      save_req = 1'b0;
      tick(3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
